// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM encoding, access-size codes
// and the default bus timeout.
package mem_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the memory stage: misalignment detection, store
// strobes/data placement and load data extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            zext,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_raw,
  output logic            misaligned,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic [7:0]      lane_mask;

  always_comb begin
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

  assign lane_mask = size_mask(size);
  assign wstrb     = lane_mask << offset;
  assign wdata     = store_data << {offset, 3'b000};
  assign shifted   = load_raw >> {offset, 3'b000};

  function automatic logic [XLEN-1:0] sign_extend(input logic [XLEN-1:0] raw,
                                                  input logic [1:0]      sz);
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [31:0]     w;
    logic signed [XLEN-1:0] r;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (sz)
      SZ_B:    r = b;
      SZ_H:    r = h;
      SZ_W:    r = w;
      default: r = raw;
    endcase
    return r;
  endfunction

  // Zero extension keeps only the lanes covered by the access size.
  always_comb begin
    keep = '0;
    for (int i = 0; i < 8; i++) begin
      keep[8*i +: 8] = {8{lane_mask[i]}};
    end
    load_data = zext ? (shifted & keep) : sign_extend(shifted, size);
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory request per load/store, stalls
// upstream until ack or timeout, and registers results into MEM/WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      func3_in,
  input  logic            RegWrite_in,
  input  logic            MemtoReg_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            valid_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic            misaligned_out,
  output logic            bus_err_out
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic [2:0]      off_p0;
  logic [1:0]      size_p0;
  logic            zext_p0;
  logic            load_p0;
  logic            regw_p0;
  logic            m2r_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] alu_p0;

  logic            is_mem;
  logic            is_store;
  logic            misaligned;
  logic            accept_mem;
  logic            pass_through;
  logic            timeout_hit;
  logic            done;
  logic [2:0]      al_off;
  logic [1:0]      al_size;
  logic            al_zext;
  logic [7:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;

  assign is_mem   = MemRead_in | MemWrite_in;
  assign is_store = MemWrite_in;

  // While waiting, lane steering must follow the captured request, not upstream.
  assign al_off  = (state == S_WAIT) ? off_p0  : alu_result_in[2:0];
  assign al_size = (state == S_WAIT) ? size_p0 : func3_in[1:0];
  assign al_zext = (state == S_WAIT) ? zext_p0 : func3_in[2];

  mem_align #(
    .XLEN(XLEN)
  ) u_align (
    .offset    (al_off),
    .size      (al_size),
    .zext      (al_zext),
    .store_data(rs2_data_in),
    .load_raw  (dmem_rdata),
    .misaligned(misaligned),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  assign accept_mem   = (state == S_IDLE) && valid_in && is_mem && !misaligned;
  assign pass_through = (state == S_IDLE) && valid_in && (!is_mem || misaligned);
  assign timeout_hit  = (state == S_WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);
  assign done         = (state == S_WAIT) && (dmem_ack || timeout_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_mem) begin
          state_nxt = S_WAIT;
          stall_out = 1'b1;
        end
      end
      S_WAIT: begin
        if (done) begin
          state_nxt = S_IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!reset) begin
      stall_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (accept_mem) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT) && !done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Request context, captured on issue (stage p0).
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      off_p0  <= alu_result_in[2:0];
      size_p0 <= func3_in[1:0];
      zext_p0 <= func3_in[2];
      load_p0 <= !MemWrite_in;
      regw_p0 <= RegWrite_in;
      m2r_p0  <= MemtoReg_in;
      rd_p0   <= rd_in;
      alu_p0  <= alu_result_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wstrb <= 8'h00;
    end else if (accept_mem) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store;
      dmem_wstrb <= is_store ? al_wstrb : 8'h00;
    end else if (done) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_wstrb <= 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_mem) begin
      dmem_addr  <= {alu_result_in[XLEN-1:3], 3'b000};
      dmem_wdata <= is_store ? al_wdata : '0;
    end
  end

  // MEM/WB boundary (stage p1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      rd_out         <= 5'd0;
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      valid_out      <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
      if (pass_through) begin
        valid_out      <= 1'b1;
        alu_result_out <= alu_result_in;
        mem_data_out   <= '0;
        rd_out         <= rd_in;
        RegWrite_out   <= RegWrite_in && !is_mem;
        MemtoReg_out   <= MemtoReg_in;
        misaligned_out <= is_mem;
      end else if (done) begin
        valid_out      <= 1'b1;
        alu_result_out <= alu_p0;
        mem_data_out   <= (dmem_ack && load_p0) ? al_load : '0;
        rd_out         <= rd_p0;
        RegWrite_out   <= regw_p0 && dmem_ack;
        MemtoReg_out   <= m2r_p0;
        bus_err_out    <= !dmem_ack;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameters: XLEN, 64, datapath width; TIMEOUT_CYCLES, 255, max WAIT cycles before bus error.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have upstream ports: valid_in  in  1; alu_result_in  in  XLEN; rs2_data_in  in  XLEN; rd_in  in  5; func3_in  in  3; RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each; stall_out  out  1, upstream holds all inputs while high.
REQ-004 SHALL have memory ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  XLEN, doubleword-aligned; dmem_wdata  out  XLEN; dmem_wstrb  out  8; dmem_rdata  in  XLEN; dmem_ack  in  1.
REQ-005 SHALL have MEM/WB outputs: valid_out  1; alu_result_out  XLEN; mem_data_out  XLEN; rd_out  5; RegWrite_out  1; MemtoReg_out  1; misaligned_out  1; bus_err_out  1.

Function
REQ-006 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-007 Non-memory op (valid_in, MemRead_in=MemWrite_in=0) in IDLE SHALL register to MEM/WB outputs next edge, valid_out=1, latency 1, stall_out=0.
REQ-008 Size SHALL be func3_in[1:0]: 00 byte, 01 half, 10 word, 11 double; func3_in[2]=1 means zero-extend loads.
REQ-009 Access SHALL be misaligned when alu_result_in is not a multiple of size; misaligned op SHALL issue no request and SHALL produce valid_out=1, misaligned_out=1, RegWrite_out=0 next edge, latency 1.
REQ-010 Aligned memory op in IDLE SHALL assert stall_out combinationally, register dmem_addr={alu_result_in[63:3],3'b0}, dmem_we, dmem_wdata, dmem_wstrb, set dmem_req=1, go to WAIT; valid_out=0 that edge.
REQ-011 Stores SHALL drive dmem_wstrb = size mask shifted left by addr[2:0] and dmem_wdata = rs2_data_in shifted left by 8*addr[2:0].
REQ-012 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb SHALL be held stable until the dmem_ack edge.
REQ-013 In WAIT with dmem_ack=1: stall_out=0 in that cycle; on that edge dmem_req drops, state returns to IDLE, and MEM/WB outputs load with valid_out=1.
REQ-014 Load data SHALL be dmem_rdata shifted right by 8*addr[2:0], then sign- or zero-extended per REQ-008 into mem_data_out; stores SHALL give mem_data_out=0.
REQ-015 Minimum memory-op latency SHALL be 2 cycles (ack in first WAIT cycle); each extra ack-wait cycle adds 1.
REQ-016 WAIT cycle counter SHALL reach TIMEOUT_CYCLES without ack -> drop dmem_req, return to IDLE, emit valid_out=1, bus_err_out=1, RegWrite_out=0.
REQ-017 MemRead_in and MemWrite_in both high SHALL be treated as a store.
REQ-018 valid_in=0 in IDLE SHALL produce valid_out=0 and no request; in WAIT, valid_out SHALL stay 0 until completion.
REQ-019 misaligned_out and bus_err_out SHALL be single-cycle qualifiers valid only with valid_out.

Reset
REQ-020 Reset low SHALL immediately force state IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, stall_out=0, all MEM/WB outputs and the timeout counter to 0, including mid-WAIT.
REQ-021 After reset release, first valid_in SHALL be accepted on the first rising edge.

Structure
REQ-022 Shared package mem_pkg SHALL hold FSM state encoding, size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and default TIMEOUT_CYCLES.
REQ-023 Combinational sub-module mem_align SHALL compute misalignment, wstrb, shifted wdata and extended load data; mem_stage holds FSM, counter and MEM/WB registers.

Verification
REQ-024 ADD (RegWrite=1, rd=5, alu=0x1234) -> next cycle valid_out=1, alu_result_out=0x1234, rd_out=5, stall_out never high.
REQ-025 LB addr 0x1003, rdata 0x00000000_80000000 -> wait, 0x...80 at byte 3 gives mem_data_out=0xFFFFFFFF_FFFFFF80; LBU same gives 0x80; ack after 3 waits -> total latency 4.
REQ-026 SH addr 0x2006, rs2=0xABCD -> dmem_addr=0x2000, wstrb=0xC0, wdata=0xABCD_0000_0000_0000, dmem_we=1.
REQ-027 LW addr 0x1002 -> no dmem_req, valid_out=1, misaligned_out=1, RegWrite_out=0 next cycle.
REQ-028 LD with no ack -> dmem_req held 255 cycles, then bus_err_out=1 and dmem_req=0; reset pulsed mid-WAIT in a second run -> dmem_req=0 and stall_out=0 immediately.
